// File: rtl/operand_fetch_stage_if.sv
// Operand fetch stage bundle: decode-side request, register file read /
// invalidate port, and issue-side result.
//   master : the operand fetch stage itself
//   slave  : the surroundings (decode, register file, execute)
// Decode  : in_valid/in_ready, in_opcode, in_src_a/b, in_use_a/b, in_dst, in_has_dst
// RegFile : rf_rd_id_a/b, rf_rd_val_a/b, rf_valid_a/b, rf_inv_en, rf_inv_id, rf_halted
// Execute : out_valid/out_ready, out_opcode, out_a/b, out_dst, out_has_dst
// Status  : stall_timeout, bad_reg_err
interface operand_fetch_stage_if #(
  parameter int REG_ID_W = 5,
  parameter int VALUE_W  = 64,
  parameter int OP_W     = 8
);
  logic                in_valid;
  logic                in_ready;
  logic [OP_W-1:0]     in_opcode;
  logic [REG_ID_W-1:0] in_src_a;
  logic [REG_ID_W-1:0] in_src_b;
  logic                in_use_a;
  logic                in_use_b;
  logic [REG_ID_W-1:0] in_dst;
  logic                in_has_dst;

  logic [REG_ID_W-1:0] rf_rd_id_a;
  logic [REG_ID_W-1:0] rf_rd_id_b;
  logic [VALUE_W-1:0]  rf_rd_val_a;
  logic [VALUE_W-1:0]  rf_rd_val_b;
  logic                rf_valid_a;
  logic                rf_valid_b;
  logic                rf_inv_en;
  logic [REG_ID_W-1:0] rf_inv_id;
  logic                rf_halted;

  logic                out_valid;
  logic                out_ready;
  logic [OP_W-1:0]     out_opcode;
  logic [VALUE_W-1:0]  out_a;
  logic [VALUE_W-1:0]  out_b;
  logic [REG_ID_W-1:0] out_dst;
  logic                out_has_dst;

  logic                stall_timeout;
  logic                bad_reg_err;

  modport master (
    input  in_valid, in_opcode, in_src_a, in_src_b, in_use_a, in_use_b, in_dst, in_has_dst,
    output in_ready,
    output rf_rd_id_a, rf_rd_id_b, rf_inv_en, rf_inv_id,
    input  rf_rd_val_a, rf_rd_val_b, rf_valid_a, rf_valid_b, rf_halted,
    output out_valid, out_opcode, out_a, out_b, out_dst, out_has_dst,
    input  out_ready,
    output stall_timeout, bad_reg_err
  );

  modport slave (
    output in_valid, in_opcode, in_src_a, in_src_b, in_use_a, in_use_b, in_dst, in_has_dst,
    input  in_ready,
    input  rf_rd_id_a, rf_rd_id_b, rf_inv_en, rf_inv_id,
    output rf_rd_val_a, rf_rd_val_b, rf_valid_a, rf_valid_b, rf_halted,
    input  out_valid, out_opcode, out_a, out_b, out_dst, out_has_dst,
    output out_ready,
    input  stall_timeout, bad_reg_err
  );
endinterface

// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: holds one decoded instruction, waits until every used
// source register is valid in the register file scoreboard, captures the
// operands, invalidates the destination and presents the instruction to
// execute with a valid/ready handshake.
// Ports:
//   clk   : clock, all state changes on posedge
//   reset : asynchronous, active-high
//   bus   : operand_fetch_stage_if.master (decode, register file, execute, status)
module operand_fetch_stage #(
  parameter int NUM_REGS    = 16,
  parameter int REG_ID_W    = 5,
  parameter int VALUE_W     = 64,
  parameter int OP_W        = 8,
  parameter int STALL_LIMIT = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  operand_fetch_stage_if.master bus
);

  typedef enum logic [1:0] {IDLE, WAIT, ISSUE} state_t;

  // Extra top bit so NUM_REGS == 2**REG_ID_W still compares correctly.
  localparam logic [REG_ID_W:0] REG_LIMIT = (REG_ID_W+1)'(NUM_REGS);
  localparam logic [15:0]       WAIT_LAST = 16'(STALL_LIMIT - 1);

  state_t              state;
  logic [OP_W-1:0]     h_opcode;
  logic [REG_ID_W-1:0] h_src_a;
  logic [REG_ID_W-1:0] h_src_b;
  logic                h_use_a;
  logic                h_use_b;
  logic [REG_ID_W-1:0] h_dst;
  logic                h_has_dst;
  logic [15:0]         wait_cnt;

  logic [OP_W-1:0]     out_opcode_q;
  logic [VALUE_W-1:0]  out_a_q;
  logic [VALUE_W-1:0]  out_b_q;
  logic [REG_ID_W-1:0] out_dst_q;
  logic                out_has_dst_q;
  logic                stall_timeout_q;
  logic                bad_reg_err_q;

  logic ready;
  logic accept;
  logic in_bad;
  logic ops_ok;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    ready = 1'b0;
    unique case (state)
      IDLE:    ready = !bus.rf_halted;
      ISSUE:   ready = bus.out_ready && !bus.rf_halted;
      default: ready = 1'b0;
    endcase
    if (reset) ready = 1'b0;
  end

  assign accept = bus.in_valid && ready;
  assign in_bad = (bus.in_use_a   && ({1'b0, bus.in_src_a} >= REG_LIMIT)) ||
                  (bus.in_use_b   && ({1'b0, bus.in_src_b} >= REG_LIMIT)) ||
                  (bus.in_has_dst && ({1'b0, bus.in_dst}   >= REG_LIMIT));
  assign ops_ok = (!h_use_a || bus.rf_valid_a) && (!h_use_b || bus.rf_valid_b);

  assign bus.in_ready      = ready;
  assign bus.rf_rd_id_a    = h_src_a;
  assign bus.rf_rd_id_b    = h_src_b;
  // Invalidation strobes in the same cycle the operands are sampled, so a
  // source equal to dst is read before the register file marks it invalid.
  assign bus.rf_inv_en     = (state == WAIT) && ops_ok && h_has_dst;
  assign bus.rf_inv_id     = h_dst;
  assign bus.out_valid     = (state == ISSUE);
  assign bus.out_opcode    = out_opcode_q;
  assign bus.out_a         = out_a_q;
  assign bus.out_b         = out_b_q;
  assign bus.out_dst       = out_dst_q;
  assign bus.out_has_dst   = out_has_dst_q;
  assign bus.stall_timeout = stall_timeout_q;
  assign bus.bad_reg_err   = bad_reg_err_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: everything here is a plain register, so the whole stage, holding
    // registers included, is cleared by reset.
    if (reset) begin
      state           <= IDLE;
      h_opcode        <= '0;
      h_src_a         <= '0;
      h_src_b         <= '0;
      h_use_a         <= 1'b0;
      h_use_b         <= 1'b0;
      h_dst           <= '0;
      h_has_dst       <= 1'b0;
      wait_cnt        <= '0;
      out_opcode_q    <= '0;
      out_a_q         <= '0;
      out_b_q         <= '0;
      out_dst_q       <= '0;
      out_has_dst_q   <= 1'b0;
      stall_timeout_q <= 1'b0;
      bad_reg_err_q   <= 1'b0;
    end else begin
      // Capture is shared by IDLE and ISSUE; an out-of-range instruction is
      // dropped and only leaves the sticky error behind.
      if (accept) begin
        if (in_bad) begin
          bad_reg_err_q <= 1'b1;
        end else begin
          h_opcode  <= bus.in_opcode;
          h_src_a   <= bus.in_src_a;
          h_src_b   <= bus.in_src_b;
          h_use_a   <= bus.in_use_a;
          h_use_b   <= bus.in_use_b;
          h_dst     <= bus.in_dst;
          h_has_dst <= bus.in_has_dst;
          wait_cnt  <= '0;
        end
      end

      unique case (state)
        IDLE: begin
          if (accept && !in_bad) state <= WAIT;
        end
        WAIT: begin
          if (ops_ok) begin
            out_opcode_q  <= h_opcode;
            out_a_q       <= h_use_a ? bus.rf_rd_val_a : '0;
            out_b_q       <= h_use_b ? bus.rf_rd_val_b : '0;
            out_dst_q     <= h_dst;
            out_has_dst_q <= h_has_dst;
            state         <= ISSUE;
          end else begin
            if (wait_cnt == WAIT_LAST) stall_timeout_q <= 1'b1;
            if (wait_cnt != 16'hFFFF)  wait_cnt <= wait_cnt + 16'd1;
          end
        end
        ISSUE: begin
          if (bus.out_ready) state <= (accept && !in_bad) ? WAIT : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
